layer0_neuron_mac: RTL and testbench
====================================

// Module: layer0_neuron_mac
// PURPOSE
//  Per-neuron multiply-accumulate stage for layer0. Consumes serial input activations and returns one
//  in_ack pulse per accepted element; in_ack feeds the layer0 input counter as its ack. Once the counter
//  raises its sticky done flag (ack_mac), this block adds the bias, applies ReLU and emits one saturated
//  output under a valid/ready handshake. It then pulses ctr_rst to re-arm the counter for the next vector.
// PARAMETERS
//  N_IN  3   inputs per neuron; must equal the counter terminal count + 1
//  DW    8   signed width of inputs, weights and bias (Q.FRAC)
//  FRAC  4   fractional bits of inputs, weights, bias and output
//  AW    20  signed accumulator width; must be >= 2*DW + clog2(N_IN)
//  OW    8   unsigned output width
// PORTS
//  clk       in   1        clock, rising edge
//  rst       in   1        synchronous, active-high reset
//  in_valid  in   1        in_data is valid this cycle
//  in_data   in   DW       signed input activation
//  in_ack    out  1        registered 1-cycle pulse per accepted input (drives counter ack)
//  ack_mac   in   1        counter done flag; sticky until the counter is reset
//  ctr_rst   out  1        1-cycle pulse that clears the counter; OR'd with rst outside this block
//  w_we      in   1        weight/bias write enable
//  w_addr    in   2        0..N_IN-1 selects a weight; N_IN selects the bias
//  w_data    in   DW       signed weight/bias value
//  out_valid out  1        result valid
//  out_data  out  OW       ReLU result, unsigned Q.FRAC, saturated
//  out_ready in   1        downstream accepts the result
//  busy      out  1        high in every state except ACCUM with idx==0
//  err       out  1        sticky: ack_mac seen before N_IN inputs accepted
// BEHAVIOUR
//  Reset: state=ACCUM, idx=0, acc=0, in_ack=0, ctr_rst=0, out_valid=0, out_data=0, err=0.
//   Weight and bias registers are cleared to 0.
//  FSM: ACCUM -> WAIT -> BIAS -> ACT -> OUT -> ACCUM.
//  ACCUM: on in_valid, acc += sext(in_data*w[idx]), idx++, in_ack=1 next cycle.
//   At idx==N_IN-1, the accepting cycle moves to WAIT. in_valid is ignored in all other states (no ack).
//  WAIT: hold until ack_mac==1, then go to BIAS. ack_mac high while in ACCUM sets err=1 and goes to BIAS
//   with a partial acc.
//  BIAS: acc += sext(bias) <<< FRAC.
//  ACT: r = (acc<0) ? 0 : acc >>> FRAC; out_data = (r > 2^OW-1) ? 2^OW-1 : r; out_valid=1.
//  OUT: out_valid and out_data hold stable until out_ready. On the out_valid && out_ready cycle:
//   out_valid=0, acc=0, idx=0, ctr_rst pulses 1 cycle, next state ACCUM.
//  Latency: ack_mac high in WAIT at cycle t -> out_valid high at t+3; back-to-back vectors are accepted
//   from t+4 if out_ready is already high.
//  ack_mac is not re-sampled until ctr_rst has been issued, so the stale sticky flag is never mistaken for
//   a new vector.
//  Weight writes: take effect the next cycle and are allowed in any state. A write in the same cycle as an
//   accept of that index uses the OLD weight.
//  Arithmetic: signed DW x DW -> 2*DW product, sign-extended to AW. The accumulator never overflows given
//   the AW constraint; no wrap handling is required.
//  err clears only on rst. rst asserted mid-vector aborts it with no in_ack, out_valid or ctr_rst issued.
// STRUCTURE
//  Shared package nn_pkg: state enum (ACCUM, WAIT, BIAS, ACT, OUT), DW/FRAC/AW defaults, and a
//   sat_relu function (acc -> OW).
//  One sub-module, neuron_wbank: N_IN+1 x DW register file with a write port and a combinational read
//   by idx, plus a bias output.
//  FSM, accumulator and handshake logic stay in this module.
// TESTING
//  1. w={16,16,16}, bias=16, in={16,32,48}, counter model acks -> out_data=112 (7.0), ctr_rst 1 pulse.
//  2. w={-16,-16,-16}, bias=16, same inputs -> acc=-1280, out_data=0.
//  3. w={127,127,127}, in={127,127,127}, bias=0 -> r=3024, out_data=255 saturated.
//  4. out_ready low for 5 cycles -> out_valid/out_data stable; in_valid ignored, no in_ack.
//  5. ack_mac forced high after the first input -> err=1, result built from one product; only rst clears err.
//  6. rst in WAIT, then vector 1 repeated -> no stale output; result 112 with exactly 3 in_ack pulses.

Source files
------------

// File: rtl/layer0_neuron_mac_pkg.sv
// Shared definitions for the layer0 neuron MAC slice.
// Contents: default widths, the FSM state type and the sat_relu helper.
// The helper turns a Q.FRAC accumulator into an unsigned Q.FRAC output.
package nn_pkg;

  localparam int NN_N_IN = 3;
  localparam int NN_DW   = 8;
  localparam int NN_FRAC = 4;
  localparam int NN_AW   = 20;
  localparam int NN_OW   = 8;

  // Largest output code, widened to the accumulator width so it can be compared directly.
  localparam logic signed [NN_AW-1:0] NN_OUT_MAX = {{(NN_AW-NN_OW){1'b0}}, {NN_OW{1'b1}}};

  typedef enum logic [2:0] {
    ACCUM = 3'd0,
    WAIT  = 3'd1,
    BIAS  = 3'd2,
    ACT   = 3'd3,
    OUT   = 3'd4
  } nn_state_e;

  // Applies ReLU, drops the extra FRAC bits from the product scaling, then clamps to OW bits.
  function automatic logic [NN_OW-1:0] sat_relu(input logic signed [NN_AW-1:0] acc);
    logic signed [NN_AW-1:0] r;
    r = acc >>> NN_FRAC;
    if (acc[NN_AW-1]) begin
      sat_relu = {NN_OW{1'b0}};
    end else if (r > NN_OUT_MAX) begin
      sat_relu = {NN_OW{1'b1}};
    end else begin
      sat_relu = r[NN_OW-1:0];
    end
  endfunction

endpackage

// File: rtl/layer0_neuron_mac_if.sv
// Bus bundle for layer0_neuron_mac.
// Groups these signals:
//   - input stream:           in_valid, in_data, in_ack
//   - counter link:           ack_mac, ctr_rst
//   - weight/bias write port: w_we, w_addr, w_data
//   - result handshake:       out_valid, out_data, out_ready
//   - status:                 busy, err
// The master modport is the environment side; the slave modport is the MAC side.
interface layer0_neuron_mac_if
  import nn_pkg::*;
#(
  parameter int DW = NN_DW,
  parameter int OW = NN_OW
);

  logic                 in_valid;
  logic signed [DW-1:0] in_data;
  logic                 in_ack;
  logic                 ack_mac;
  logic                 ctr_rst;
  logic                 w_we;
  logic [1:0]           w_addr;
  logic signed [DW-1:0] w_data;
  logic                 out_valid;
  logic [OW-1:0]        out_data;
  logic                 out_ready;
  logic                 busy;
  logic                 err;

  modport master (
    output in_valid, in_data, ack_mac, w_we, w_addr, w_data, out_ready,
    input  in_ack, ctr_rst, out_valid, out_data, busy, err
  );

  modport slave (
    input  in_valid, in_data, ack_mac, w_we, w_addr, w_data, out_ready,
    output in_ack, ctr_rst, out_valid, out_data, busy, err
  );

endinterface

// File: rtl/layer0_neuron_mac_wbank.sv
// Weight and bias register file for one neuron.
// Ports:
//   clk, rst            clock and synchronous active-high reset (clears all entries)
//   w_we/w_addr/w_data  write port; a write is visible from the next cycle
//   rd_idx/rd_data      combinational weight read
//   bias                combinational read of entry N_IN
// The array spans the whole 2-bit address space, so any w_addr is a legal write target.
module neuron_wbank #(
  parameter int N_IN = 3,
  parameter int DW   = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 w_we,
  input  logic [1:0]           w_addr,
  input  logic signed [DW-1:0] w_data,
  input  logic [1:0]           rd_idx,
  output logic signed [DW-1:0] rd_data,
  output logic signed [DW-1:0] bias
);

  logic signed [DW-1:0] w_r [0:3];

  // Register file write port with reset clear
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < 4; i++) begin
        w_r[i] <= {DW{1'b0}};
      end
    end else if (w_we) begin
      w_r[w_addr] <= w_data;
    end
  end

  assign rd_data = w_r[rd_idx];
  assign bias    = w_r[N_IN];

endmodule

// File: rtl/layer0_neuron_mac.sv
// Per-neuron multiply-accumulate stage for layer0.
// Ports:
//   clk   clock
//   rst   synchronous active-high reset
//   bus   layer0_neuron_mac_if.slave, carrying:
//           - input stream and its in_ack pulses
//           - ack_mac / ctr_rst counter link
//           - weight/bias write port
//           - valid/ready result port
//           - busy and err status
// Flow: accumulate N_IN products, wait for the counter's done flag, add the bias,
// then apply saturating ReLU. The result is held until accepted, then ctr_rst re-arms the counter.
module layer0_neuron_mac
  import nn_pkg::*;
#(
  parameter int N_IN = NN_N_IN,
  parameter int DW   = NN_DW,
  parameter int FRAC = NN_FRAC,
  parameter int AW   = NN_AW,
  parameter int OW   = NN_OW
) (
  input logic clk,
  input logic rst,
  layer0_neuron_mac_if.slave bus
);

  nn_state_e              state_r;
  nn_state_e              state_nxt_s;
  logic [1:0]             idx_r;
  logic [1:0]             idx_nxt_s;
  logic signed [AW-1:0]   acc_r;
  logic                   in_ack_r;
  logic                   ctr_rst_r;
  logic                   out_valid_r;
  logic [OW-1:0]          out_data_r;
  logic                   err_r;
  logic                   busy_r;

  logic                   accept_s;
  logic                   err_set_s;
  logic                   done_s;
  logic                   ack_live_s;
  logic signed [DW-1:0]   w_rd_s;
  logic signed [DW-1:0]   bias_s;
  logic signed [2*DW-1:0] prod_s;
  logic signed [AW-1:0]   prod_ext_s;
  logic signed [AW-1:0]   bias_ext_s;

  neuron_wbank #(
    .N_IN (N_IN),
    .DW   (DW)
  ) u_wbank (
    .clk     (clk),
    .rst     (rst),
    .w_we    (bus.w_we),
    .w_addr  (bus.w_addr),
    .w_data  (bus.w_data),
    .rd_idx  (idx_r),
    .rd_data (w_rd_s),
    .bias    (bias_s)
  );

  // The counter only clears on the edge that ends the ctr_rst cycle. During that cycle its
  // sticky done flag still belongs to the previous vector, so it is masked.
  assign ack_live_s = bus.ack_mac & ~ctr_rst_r;

  assign prod_s     = $signed(bus.in_data) * $signed(w_rd_s);
  assign prod_ext_s = {{(AW-2*DW){prod_s[2*DW-1]}}, prod_s};
  // The bias is Q.FRAC while the products are Q.2FRAC, so the bias is aligned before adding.
  assign bias_ext_s = {{(AW-DW){bias_s[DW-1]}}, bias_s} <<< FRAC;

  // FSM state register
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r <= ACCUM;
    end else begin
      state_r <= state_nxt_s;
    end
  end

  // Next-state decode and per-cycle control strobes
  always_comb begin
    state_nxt_s = state_r;
    accept_s    = 1'b0;
    err_set_s   = 1'b0;
    done_s      = 1'b0;
    case (state_r)
      ACCUM: begin
        // An early done flag wins over a concurrent input, and the partial sum is finished off.
        if (ack_live_s) begin
          err_set_s   = 1'b1;
          state_nxt_s = BIAS;
        end else if (bus.in_valid) begin
          accept_s = 1'b1;
          if (idx_r == 2'(N_IN - 1)) begin
            state_nxt_s = WAIT;
          end else begin
            state_nxt_s = ACCUM;
          end
        end else begin
          state_nxt_s = ACCUM;
        end
      end
      WAIT: begin
        if (ack_live_s) begin
          state_nxt_s = BIAS;
        end else begin
          state_nxt_s = WAIT;
        end
      end
      BIAS: state_nxt_s = ACT;
      ACT:  state_nxt_s = OUT;
      OUT: begin
        if (bus.out_ready) begin
          done_s      = 1'b1;
          state_nxt_s = ACCUM;
        end else begin
          state_nxt_s = OUT;
        end
      end
      default: state_nxt_s = ACCUM;
    endcase
  end

  // Element index for the next cycle
  always_comb begin
    idx_nxt_s = idx_r;
    if (done_s) begin
      idx_nxt_s = 2'd0;
    end else if (accept_s) begin
      idx_nxt_s = idx_r + 2'd1;
    end else begin
      idx_nxt_s = idx_r;
    end
  end

  // Accumulator, index and registered handshake/status outputs
  always_ff @(posedge clk) begin
    if (rst) begin
      idx_r       <= 2'd0;
      acc_r       <= {AW{1'b0}};
      in_ack_r    <= 1'b0;
      ctr_rst_r   <= 1'b0;
      out_valid_r <= 1'b0;
      out_data_r  <= {OW{1'b0}};
      err_r       <= 1'b0;
      busy_r      <= 1'b0;
    end else begin
      idx_r     <= idx_nxt_s;
      in_ack_r  <= accept_s;
      ctr_rst_r <= done_s;
      err_r     <= err_r | err_set_s;
      busy_r    <= ~((state_nxt_s == ACCUM) && (idx_nxt_s == 2'd0));
      case (state_r)
        ACCUM: begin
          if (accept_s) begin
            acc_r <= acc_r + prod_ext_s;
          end
        end
        BIAS: acc_r <= acc_r + bias_ext_s;
        ACT: begin
          out_valid_r <= 1'b1;
          out_data_r  <= sat_relu(acc_r);
        end
        OUT: begin
          if (done_s) begin
            out_valid_r <= 1'b0;
            acc_r       <= {AW{1'b0}};
          end
        end
        default: ;
      endcase
    end
  end

  assign bus.in_ack    = in_ack_r;
  assign bus.ctr_rst   = ctr_rst_r;
  assign bus.out_valid = out_valid_r;
  assign bus.out_data  = out_data_r;
  assign bus.busy      = busy_r;
  assign bus.err       = err_r;

endmodule

// File: tb/tb_layer0_neuron_mac.sv
// Self-checking bench for layer0_neuron_mac.
// A behavioural input counter closes the in_ack -> ack_mac loop.
// Expected results are queued when a vector is driven and compared when the result handshake completes.
module tb_layer0_neuron_mac;

  logic clk;
  logic rst;
  logic force_ack;
  logic ctr_done;
  logic [1:0] ctr_cnt;

  int n_checks;
  int n_errors;
  int ack_cnt;
  int crst_cnt;
  int out_cnt;
  int exp_q[$];

  layer0_neuron_mac_if #(.DW(8), .OW(8)) bus ();

  layer0_neuron_mac dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Input counter model: terminal count 2, sticky done, cleared by rst or ctr_rst.
  always @(posedge clk) begin
    if (rst || bus.ctr_rst) begin
      ctr_cnt  <= 2'd0;
      ctr_done <= 1'b0;
    end else if (bus.in_ack) begin
      if (ctr_cnt == 2'd2) ctr_done <= 1'b1;
      else ctr_cnt <= ctr_cnt + 2'd1;
    end
  end

  assign bus.ack_mac = ctr_done | force_ack;

  task automatic check_eq(input string tag, input int got, input int exp);
    n_checks++;
    if (got != exp) begin
      n_errors++;
      $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
    end
  endtask

  // Monitor on the falling edge, away from the active edge.
  always @(negedge clk) begin
    if (!rst) begin
      if (bus.in_ack) ack_cnt++;
      if (bus.ctr_rst) crst_cnt++;
      if (bus.out_valid && bus.out_ready) begin
        out_cnt++;
        if (exp_q.size() == 0) check_eq("unexpected_out", int'(bus.out_data), -1);
        else check_eq("out_data", int'(bus.out_data), exp_q.pop_front());
      end
    end
  end

  task automatic tick(input int n = 1);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic write_w(input logic [1:0] addr, input logic [7:0] data);
    bus.w_we   = 1'b1;
    bus.w_addr = addr;
    bus.w_data = data;
    tick();
    bus.w_we   = 1'b0;
  endtask

  task automatic load_w(input logic [7:0] w, input logic [7:0] b);
    write_w(2'd0, w);
    write_w(2'd1, w);
    write_w(2'd2, w);
    write_w(2'd3, b);
  endtask

  task automatic send_vec(input logic [7:0] a, input logic [7:0] b, input logic [7:0] c);
    bus.in_valid = 1'b1;
    bus.in_data  = a;
    tick();
    bus.in_data  = b;
    tick();
    bus.in_data  = c;
    tick();
    bus.in_valid = 1'b0;
  endtask

  task automatic wait_out(input int start);
    int k;
    k = 0;
    while (out_cnt == start && k < 40) begin
      tick();
      k++;
    end
    if (out_cnt == start) check_eq("out_timeout", 0, 1);
  endtask

  task automatic run_vec(input logic [7:0] a, input logic [7:0] b, input logic [7:0] c,
                         input int exp, input string tag);
    int start;
    ack_cnt  = 0;
    crst_cnt = 0;
    exp_q.push_back(exp);
    start = out_cnt;
    send_vec(a, b, c);
    wait_out(start);
    tick(2);
    check_eq({tag, "_in_ack"}, ack_cnt, 3);
    check_eq({tag, "_ctr_rst"}, crst_cnt, 1);
  endtask

  initial begin
    int start;
    int k;
    n_checks = 0; n_errors = 0;
    ack_cnt = 0; crst_cnt = 0; out_cnt = 0;
    rst = 1'b1; force_ack = 1'b0;
    bus.in_valid = 1'b0; bus.in_data = 8'd0;
    bus.w_we = 1'b0; bus.w_addr = 2'd0; bus.w_data = 8'd0;
    bus.out_ready = 1'b1;
    tick(3);
    rst = 1'b0;

    check_eq("rst_out_valid", int'(bus.out_valid), 0);
    check_eq("rst_out_data", int'(bus.out_data), 0);
    check_eq("rst_in_ack", int'(bus.in_ack), 0);
    check_eq("rst_ctr_rst", int'(bus.ctr_rst), 0);
    check_eq("rst_busy", int'(bus.busy), 0);
    check_eq("rst_err", int'(bus.err), 0);

    // 1: basic vector
    load_w(8'd16, 8'd16);
    run_vec(8'd16, 8'd32, 8'd48, 112, "v1");
    check_eq("v1_err", int'(bus.err), 0);
    check_eq("v1_idle_busy", int'(bus.busy), 0);

    // 2: negative sum clamps to zero
    load_w(8'hF0, 8'd16);
    run_vec(8'd16, 8'd32, 8'd48, 0, "v2");

    // 3: positive saturation
    load_w(8'd127, 8'd0);
    run_vec(8'd127, 8'd127, 8'd127, 255, "v3");

    // 4: output stall, inputs ignored while holding
    load_w(8'd16, 8'd16);
    ack_cnt = 0;
    crst_cnt = 0;
    bus.out_ready = 1'b0;
    exp_q.push_back(112);
    start = out_cnt;
    send_vec(8'd16, 8'd32, 8'd48);
    k = 0;
    while (!bus.out_valid && k < 20) begin
      tick();
      k++;
    end
    check_eq("v4_valid_seen", int'(bus.out_valid), 1);
    for (int i = 0; i < 5; i++) begin
      bus.in_valid = 1'b1;
      bus.in_data  = 8'd5;
      tick();
      check_eq("v4_hold_valid", int'(bus.out_valid), 1);
      check_eq("v4_hold_data", int'(bus.out_data), 112);
      check_eq("v4_hold_busy", int'(bus.busy), 1);
    end
    bus.in_valid = 1'b0;
    check_eq("v4_in_ack", ack_cnt, 3);
    check_eq("v4_no_early_out", out_cnt - start, 0);
    bus.out_ready = 1'b1;
    wait_out(start);
    tick(2);
    check_eq("v4_ctr_rst", crst_cnt, 1);

    // 5: done flag arrives after a single input
    ack_cnt = 0;
    crst_cnt = 0;
    exp_q.push_back(32);
    start = out_cnt;
    bus.in_valid = 1'b1;
    bus.in_data  = 8'd16;
    tick();
    bus.in_valid = 1'b0;
    force_ack = 1'b1;
    wait_out(start);
    force_ack = 1'b0;
    tick(2);
    check_eq("v5_err", int'(bus.err), 1);
    check_eq("v5_in_ack", ack_cnt, 1);
    check_eq("v5_ctr_rst", crst_cnt, 1);
    run_vec(8'd16, 8'd32, 8'd48, 112, "v5b");
    check_eq("v5_err_sticky", int'(bus.err), 1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check_eq("v5_err_cleared", int'(bus.err), 0);

    // 6: reset while waiting for the counter
    load_w(8'd16, 8'd16);
    start = out_cnt;
    send_vec(8'd16, 8'd32, 8'd48);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    ack_cnt = 0;
    crst_cnt = 0;
    tick(10);
    check_eq("v6_no_stale_out", out_cnt - start, 0);
    check_eq("v6_no_in_ack", ack_cnt, 0);
    check_eq("v6_no_ctr_rst", crst_cnt, 0);
    check_eq("v6_busy", int'(bus.busy), 0);
    load_w(8'd16, 8'd16);
    run_vec(8'd16, 8'd32, 8'd48, 112, "v6");

    // 7: weight write colliding with the accept of that index uses the old weight
    exp_q.push_back(112);
    start = out_cnt;
    bus.in_valid = 1'b1;
    bus.in_data  = 8'd16;
    bus.w_we     = 1'b1;
    bus.w_addr   = 2'd0;
    bus.w_data   = 8'd32;
    tick();
    bus.w_we     = 1'b0;
    bus.in_data  = 8'd32;
    tick();
    bus.in_data  = 8'd48;
    tick();
    bus.in_valid = 1'b0;
    wait_out(start);
    tick(2);
    run_vec(8'd16, 8'd32, 8'd48, 128, "v7");

    tick(2);
    check_eq("final_queue_empty", exp_q.size(), 0);
    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

endmodule
